// File: rtl/stopwatch_control.sv
// Stopwatch command sequencer: synchronizes and debounces three pushbuttons,
// turns debounced rising edges into press events and drives the command bus.
//
// state   | meaning
// IDLE    | stopwatch cleared, not counting
// RUNNING | counting, control[0] held high
// PAUSED  | stopped, count held for display
module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    output logic [2:0] control,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;

    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       level;
    logic [2:0]       level_d;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];
    state_t           state_q;

    assign raw   = {btn_reset, btn_stop, btn_start};
    assign press = level & ~level_d;
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Only the highest-priority press is considered; a losing press is dropped
    // even if the winner turns out to be ignored in the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            control <= 3'b000;
        end else if (press[BTN_CLEAR]) begin
            state_q <= IDLE;
            control <= 3'b010;
        end else if (press[BTN_STOP]) begin
            if (state_q == RUNNING) begin
                state_q <= PAUSED;
                control <= 3'b100;
            end else begin
                control <= 3'b000;
            end
        end else if (press[BTN_START]) begin
            state_q <= RUNNING;
            control <= 3'b001;
        end else begin
            control <= {2'b00, state_q == RUNNING};
        end
    end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, the debounce counter width; CNT_W SHALL be large enough to hold DEBOUNCE_CYCLES-1.
REQ-003 SHALL use one clock and a synchronous, active-high reset; port clk, input, 1 bit, rising-edge system clock.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port btn_start, input, 1 bit, raw asynchronous start pushbutton (active-high).
REQ-006 SHALL have port btn_stop, input, 1 bit, raw asynchronous stop pushbutton (active-high).
REQ-007 SHALL have port btn_reset, input, 1 bit, raw asynchronous stopwatch-clear pushbutton (active-high).
REQ-008 SHALL have port control, output, 3 bits, the stopwatch command bus: bit0 = start (level), bit1 = clear (pulse), bit2 = stop (pulse).
REQ-009 SHALL have port state, output, 2 bits, current FSM state: 00 = IDLE, 01 = RUNNING, 10 = PAUSED.
REQ-010 SHALL drive all outputs from registers.

Function
REQ-011 SHALL pass each button through its own two-flop synchronizer before any other logic.
REQ-012 Per-button debounce: the counter SHALL clear whenever the synchronized value equals the debounced level, and SHALL otherwise increment.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear on that same edge.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced level.
REQ-015 A press event SHALL be a one-cycle rising edge of the debounced level; release edges SHALL be ignored.
REQ-016 Latency: control and state SHALL change exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the new raw level.
REQ-017 FSM transitions: IDLE on start press -> RUNNING; RUNNING on stop press -> PAUSED; PAUSED on start press -> RUNNING; any state on clear press -> IDLE.
REQ-018 All other press events SHALL be ignored, with no state change and no control pulse; this covers start while RUNNING, stop while IDLE, and stop while PAUSED.
REQ-019 control[0] SHALL be 1 exactly while state = RUNNING, changing on the same edge as state.
REQ-020 control[2] SHALL be a one-cycle pulse on the edge of the RUNNING -> PAUSED transition only.
REQ-021 control[1] SHALL be a one-cycle pulse on every accepted clear press, including a press while already IDLE, on the edge state becomes IDLE.
REQ-022 Simultaneous press events in one cycle SHALL be prioritized clear > stop > start; only the winner is acted on and the losers are discarded.
REQ-023 control[1] and control[2] SHALL never be 1 in the same cycle, and control[0] SHALL be 0 in any cycle where control[1] is 1.
REQ-024 A button held indefinitely SHALL produce exactly one press event.

Reset
REQ-025 While reset = 1 at a clock edge, the block SHALL clear all synchronizer flops, debounce counters and debounced levels to 0, set state to IDLE (00), and set control to 000.
REQ-026 Reset SHALL take priority over all button activity, including a debounce already in progress, which is abandoned.
REQ-027 A button held high across reset release SHALL be treated as a new press after DEBOUNCE_CYCLES+3 edges, because the debounced levels restart at 0.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Assert reset for 2 cycles, release it, and hold btn_start high -> control = 000 for 6 edges, then control = 001 and state = 01 on the 7th edge.
REQ-029 From RUNNING, pulse btn_stop high for 3 cycles (a glitch) -> no change. Then hold btn_stop for 10 cycles -> control = 100 for exactly one cycle, then 000, with state = 10.
REQ-030 From PAUSED, press btn_start -> control[0] = 1 and state = 01. Then press btn_start again -> no change and no pulse.
REQ-031 From RUNNING, raise btn_start, btn_stop and btn_reset on the same edge -> a single control = 010 pulse, then 000, with state = 00.
REQ-032 From IDLE, press btn_stop -> no pulse and state stays 00. Then press btn_reset -> one control = 010 pulse.
REQ-033 Assert reset mid-debounce, 2 cycles into a btn_start press, while RUNNING -> next edge control = 000 and state = 00. Keep btn_start held after release -> RUNNING 7 edges later.
